jala_mem_responder: RTL
=======================

Name: jala_mem_responder

Overview:
- Memory-side responder for the dual-port memory request interface driven by the multicycle control unit: MemRead1/MemWrite1 and MemRead2/MemWrite2 with per-port address and write data.
- Holds a word-addressed RAM.
- Accepts at most one request per port at a time. Writes acknowledge after one cycle; reads return data after a programmable latency.
- Port-status outputs tell the control unit when to stall its state machine.

Parameters:
- DEPTH, 1024, number of 16-bit words; addresses index 0..DEPTH-1.
- READ_LAT, 2, read latency in cycles from accept to RValid; legal range 1..4.

Ports:
- CLK  in  1  system clock, rising edge.
- RstN  in  1  synchronous active-low reset.
- MemRead1  in  1  port-1 read request.
- MemWrite1  in  1  port-1 write request.
- Addr1  in  16  port-1 word address.
- WData1  in  16  port-1 write data.
- RData1  out  16  port-1 read data, valid when RValid1=1.
- RValid1  out  1  one-cycle pulse: RData1 holds read result.
- WAck1  out  1  one-cycle pulse: port-1 write committed.
- Busy1  out  1  port 1 cannot accept a request this cycle.
- MemRead2, MemWrite2, Addr2, WData2, RData2, RValid2, WAck2, Busy2: same as port 1, for port 2.
- Overrun  out  1  sticky: a request arrived while its port was busy, or both read and write were asserted on one port.
- Fault  out  1  sticky address-range fault; tied 0 unless ADDR_CHECK_EN.

Behaviour:
- Reset (RstN=0 sampled at CLK edge):
  - All outputs go to 0; both port FSMs go to IDLE; latency counters clear.
  - RAM contents are not cleared.
  - Reset has priority over any request in the same cycle.
  - Reset mid-read aborts the read; no RValid is issued afterward.
- Per-port FSM, states IDLE, RD_WAIT, WR_ACK:
  - IDLE with MemRead=1 and MemWrite=0 -> RD_WAIT. The RAM word is captured this cycle into a read holding register. Cnt=READ_LAT-1.
  - IDLE with MemWrite=1 and MemRead=0 -> WR_ACK. RAM[Addr] is written at this edge.
  - IDLE with both MemRead and MemWrite=1 -> request ignored, Overrun set, stay in IDLE.
  - RD_WAIT: if Cnt==0, RValid=1 and RData=held word for exactly one cycle, then -> IDLE; otherwise Cnt decrements.
  - With READ_LAT=1: request accepted at edge N, RValid high in the cycle following edge N.
  - WR_ACK: WAck=1 for one cycle, then -> IDLE.
- Busy=1 whenever the state is not IDLE. A request seen with Busy=1 is dropped and sets Overrun.
- Back-to-back: a new request is accepted on the cycle the port returns to IDLE. It may not be accepted in the RValid/WAck cycle itself.
- RData holds its last value between RValid pulses.
- Address wrap (no ADDR_CHECK_EN): effective address = Addr mod DEPTH when DEPTH is a power of two; otherwise Addr[clog2(DEPTH)-1:0] with out-of-range indices aliasing to Addr - DEPTH.
- Simultaneous events, same cycle, both ports IDLE:
  - Both ports write the same address -> port 1's data wins. Both ports still receive WAck.
  - One port reads while the other writes the same address -> the reader gets the old (pre-write) word, i.e. read-before-write.
- Overrun and Fault clear only on reset.

Optional Feature:
- Macro: ADDR_CHECK_EN.
- Defined:
  - A request with Addr >= DEPTH is not performed and sets Fault.
  - A faulting read still completes the handshake with RData=16'h0000 and RValid after READ_LAT.
  - A faulting write still gets WAck but the RAM is unchanged.
- Undefined: wrap rules apply and Fault is constant 0.

Test Plan:
- Write then read, port 1, READ_LAT=2:
  - Write Addr1=0x0010, WData1=0xBEEF -> WAck1 pulses one cycle later.
  - Then read 0x0010 -> RValid1 pulses 2 cycles after accept, with RData1=0xBEEF.
- Busy and overrun:
  - Read on port 2, then assert MemRead2 again on the next cycle -> Busy2=1, second request dropped, Overrun=1.
  - Exactly one RValid2 pulse is issued.
- Same-address collision:
  - Both ports write Addr=0x0005 in one cycle, data 0x1111 (port 1) and 0x2222 (port 2) -> both WAck.
  - A later read of 0x0005 returns 0x1111.
- Read/write same cycle:
  - RAM[0x20]=0x00AA; port 1 reads 0x20 while port 2 writes 0x0055 to 0x20 -> RData1=0x00AA.
  - A subsequent read returns 0x0055.
- Reset mid-read:
  - Issue a read with READ_LAT=4, drive RstN=0 two cycles later -> no RValid1 ever appears.
  - Busy1=0 and Overrun=0 after reset; RAM contents are retained.
- ADDR_CHECK_EN, DEPTH=1024:
  - Write 0x1234 to Addr1=0x0400 -> WAck1 and Fault=1.
  - A read of 0x0400 returns 0x0000.
  - Without the macro, the same write lands at 0x0000.

Source files
------------

// File: rtl/jala_mem_responder.sv
// jala_mem_responder: dual-port word RAM responder with stall/busy status for the multicycle control unit.
// Optional ADDR_CHECK_EN: out-of-range requests are not performed and set Fault instead of wrapping.
module jala_mem_responder #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2
) (
    input  logic        CLK,
    input  logic        RstN,
    input  logic        MemRead1,
    input  logic        MemWrite1,
    input  logic [15:0] Addr1,
    input  logic [15:0] WData1,
    output logic [15:0] RData1,
    output logic        RValid1,
    output logic        WAck1,
    output logic        Busy1,
    input  logic        MemRead2,
    input  logic        MemWrite2,
    input  logic [15:0] Addr2,
    input  logic [15:0] WData2,
    output logic [15:0] RData2,
    output logic        RValid2,
    output logic        WAck2,
    output logic        Busy2,
    output logic        Overrun,
    output logic        Fault
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] MASK = 16'((1 << AW) - 1);
    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK} state_t;

    logic [1:0]          w_rd, w_wr, w_acc_rd, w_acc_wr, w_oob, w_rvalid, w_wack, w_busy, w_ovr;
    logic [1:0][15:0]    w_addr, w_wdata, r_hold, r_rdata;
    logic [1:0][AW-1:0]  w_low, w_idx;
    logic [1:0][1:0]     r_cnt, w_cnt_next;
    state_t              r_state [2];
    state_t              w_next [2];
    logic                r_ovr, r_fault;
    logic [15:0]         r_mem [DEPTH];

    assign w_rd    = {MemRead2, MemRead1};
    assign w_wr    = {MemWrite2, MemWrite1};
    assign w_addr  = {Addr2, Addr1};
    assign w_wdata = {WData2, WData1};

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // Low address bits index the RAM; indices past DEPTH alias down by DEPTH.
            w_low[p]      = AW'(w_addr[p] & MASK);
            w_idx[p]      = (32'(w_low[p]) >= DEPTH) ? w_low[p] - AW'(DEPTH) : w_low[p];
`ifdef ADDR_CHECK_EN
            w_oob[p]      = 32'(w_addr[p]) >= DEPTH;
`else
            w_oob[p]      = 1'b0;
`endif
            w_busy[p]     = r_state[p] != IDLE;
            w_acc_rd[p]   = !w_busy[p] && w_rd[p] && !w_wr[p];
            w_acc_wr[p]   = !w_busy[p] && w_wr[p] && !w_rd[p];
            w_ovr[p]      = (w_busy[p] && (w_rd[p] || w_wr[p])) || (w_rd[p] && w_wr[p]);
            w_rvalid[p]   = (r_state[p] == RD_WAIT) && (r_cnt[p] == 2'd0);
            w_wack[p]     = r_state[p] == WR_ACK;
            w_next[p]     = w_acc_rd[p] ? RD_WAIT :
                            w_acc_wr[p] ? WR_ACK :
                            (w_rvalid[p] || w_wack[p]) ? IDLE : r_state[p];
            w_cnt_next[p] = w_acc_rd[p] ? CNT_INIT :
                            (r_state[p] == RD_WAIT && r_cnt[p] != 2'd0) ? r_cnt[p] - 2'd1 : r_cnt[p];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RstN) begin
            r_state[0] <= IDLE;
            r_state[1] <= IDLE;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_rdata    <= '0;
            r_ovr      <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_state[p] <= w_next[p];
                r_cnt[p]   <= w_cnt_next[p];
                if (w_acc_rd[p])
                    r_hold[p] <= w_oob[p] ? 16'h0000 : r_mem[w_idx[p]];
                if (w_rvalid[p])
                    r_rdata[p] <= r_hold[p];
            end
            r_ovr   <= r_ovr | (|w_ovr);
            r_fault <= r_fault | (|(w_oob & (w_acc_rd | w_acc_wr)));
        end
    end

    // Port 1 is written last so it wins a same-address collision; reads above see the old word.
    always_ff @(posedge CLK) begin
        if (RstN && w_acc_wr[1] && !w_oob[1])
            r_mem[w_idx[1]] <= w_wdata[1];
        if (RstN && w_acc_wr[0] && !w_oob[0])
            r_mem[w_idx[0]] <= w_wdata[0];
    end

    assign RData1  = w_rvalid[0] ? r_hold[0] : r_rdata[0];
    assign RData2  = w_rvalid[1] ? r_hold[1] : r_rdata[1];
    assign RValid1 = w_rvalid[0];
    assign RValid2 = w_rvalid[1];
    assign WAck1   = w_wack[0];
    assign WAck2   = w_wack[1];
    assign Busy1   = w_busy[0];
    assign Busy2   = w_busy[1];
    assign Overrun = r_ovr;
    assign Fault   = r_fault;
endmodule
